// File: rtl/crossbar_slave_arbiter_if.sv
// -----------------------------------------------------------------------------
// crossbar_slave_arbiter_if
//   Bundle of signals between one crossbar slave port and its arbiter.
//
//   Parameters
//     NM        number of masters sharing the slave
//     LGMAXOUT  log2 of the outstanding-transaction limit
//
//   Signals
//     i_request      [NM]          per-master request (master valid && decode hit)
//     i_issue        1             address handshake completed on granted channel
//     i_retire       1             response handshake completed
//     o_grant        [NM]          one-hot grant, zero when idle
//     o_grant_valid  1             OR of o_grant
//     o_grant_idx    [IW]          index of granted master, holds when idle
//     o_stall        1             new issue not permitted
//     o_outstanding  [LGMAXOUT+1]  outstanding transaction count
//     o_err          1             sticky protocol-error flag
//
//   Modports
//     master  crossbar side: drives requests/handshakes, observes grant
//     slave   arbiter side
// -----------------------------------------------------------------------------
interface crossbar_slave_arbiter_if #(
  parameter int NM       = 4,
  parameter int LGMAXOUT = 3
);
  localparam int IW = (NM > 1) ? $clog2(NM) : 1;

  logic [NM-1:0]     i_request;
  logic              i_issue;
  logic              i_retire;
  logic [NM-1:0]     o_grant;
  logic              o_grant_valid;
  logic [IW-1:0]     o_grant_idx;
  logic              o_stall;
  logic [LGMAXOUT:0] o_outstanding;
  logic              o_err;

  modport master (
    output i_request, i_issue, i_retire,
    input  o_grant, o_grant_valid, o_grant_idx, o_stall, o_outstanding, o_err
  );

  modport slave (
    input  i_request, i_issue, i_retire,
    output o_grant, o_grant_valid, o_grant_idx, o_stall, o_outstanding, o_err
  );
endinterface

// File: rtl/crossbar_slave_arbiter.sv
// -----------------------------------------------------------------------------
// crossbar_slave_arbiter
//   Per-slave arbiter for the AXI-lite crossbar. Shares one slave port among
//   NM masters with round-robin selection. The grant stays locked while the
//   holder keeps requesting or still has transactions outstanding, so every
//   response routes back to the master that issued it. New issues stall when
//   the outstanding counter reaches MAXOUT = 2**LGMAXOUT - 1.
//
//   Ports
//     clock  system clock
//     reset  synchronous, active-high
//     bus    crossbar_slave_arbiter_if.slave (request/issue/retire in,
//            grant/stall/outstanding/err out)
//
//   Optional feature
//     `define ARBITER_HOLD_LIMIT_EN to force a handoff after MAX_HOLD
//     consecutive issues by one holder while another master is waiting.
//     Undefined (default): the holder may keep the slave indefinitely.
// -----------------------------------------------------------------------------
module crossbar_slave_arbiter #(
  parameter int NM       = 4,
  parameter int LGMAXOUT = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  crossbar_slave_arbiter_if.slave  bus
);

  localparam int IW = (NM > 1) ? $clog2(NM) : 1;
  localparam logic [LGMAXOUT:0] MAXOUT = {1'b0, {LGMAXOUT{1'b1}}};

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_GRANTED  = 2'd1;
  localparam logic [1:0] S_DRAINING = 2'd2;

  // Reject nonsensical configurations at elaboration.
  if (NM < 1 || LGMAXOUT < 1 || MAX_HOLD < 1) begin : g_param_check
    $error("crossbar_slave_arbiter: NM, LGMAXOUT and MAX_HOLD must be >= 1");
  end

  logic [1:0]        state;
  logic [IW-1:0]     ptr;       // round-robin pointer, doubles as grant index
  logic [LGMAXOUT:0] count;
  logic              err;

  logic [IW-1:0]     winner;
  logic              holder_req;
  logic              granted;
  logic [NM-1:0]     grant;
  logic              stall;
  logic              handoff_pending;
  logic              issue_ok;
  logic              retire_ok;
  logic [LGMAXOUT:0] count_next;

  // Grant is decoded from registered state, so it appears one cycle after
  // the arbitration decision.
  assign granted    = (state != S_IDLE);
  assign grant      = granted ? (NM'(1) << ptr) : '0;
  assign holder_req = bus.i_request[ptr];

  assign stall = !granted || (count == MAXOUT) || (state == S_DRAINING)
                 || handoff_pending;

  // Illegal handshakes are flagged and ignored by the counter; a retire at
  // zero does not cancel a legal issue in the same cycle.
  assign issue_ok   = bus.i_issue && !stall;
  assign retire_ok  = bus.i_retire && (count != '0);
  assign count_next = count + {{LGMAXOUT{1'b0}}, issue_ok}
                            - {{LGMAXOUT{1'b0}}, retire_ok};

  // Round-robin search: first requester strictly after the last winner,
  // wrapping back to the last winner itself.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    logic found;
    int   cand;
    winner = ptr;
    found  = 1'b0;
    cand   = 0;
    for (int k = 1; k <= NM; k++) begin
      cand = (int'(ptr) + k) % NM;
      if (!found && bus.i_request[cand]) begin
        winner = IW'(cand);
        found  = 1'b1;
      end
    end
  end

`ifdef ARBITER_HOLD_LIMIT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] hold_cnt;
  logic          others_req;

  assign others_req      = |(bus.i_request & ~grant);
  assign handoff_pending = granted && (hold_cnt == HW'(MAX_HOLD)) && others_req;

  // Counts issues within one tenure; cleared while idle so every new grant
  // starts from zero. A holder returning from DRAINING keeps its tally.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (state == S_IDLE) begin
      hold_cnt <= '0;
    end else if (state == S_GRANTED && issue_ok && hold_cnt != HW'(MAX_HOLD)) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign handoff_pending = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      ptr   <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      count <= count_next;
      if ((bus.i_issue && stall) || (bus.i_retire && count == '0)) begin
        err <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (|bus.i_request) begin
            state <= S_GRANTED;
            ptr   <= winner;
          end
        end
        S_GRANTED: begin
          if (!holder_req || handoff_pending) begin
            state <= (count_next == '0) ? S_IDLE : S_DRAINING;
          end
        end
        S_DRAINING: begin
          if (count_next == '0) begin
            state <= S_IDLE;
          end else if (holder_req && !handoff_pending) begin
            state <= S_GRANTED;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_grant       = grant;
  assign bus.o_grant_valid = granted;
  assign bus.o_grant_idx   = ptr;
  assign bus.o_stall       = stall;
  assign bus.o_outstanding = count;
  assign bus.o_err         = err;

endmodule
